// File: rtl/store_buf_pkg.sv
// Shared types for the store buffer: op encodings, buffer entry layout, default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buf_pkg;

    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_SW  = 2'd0,
        OP_SB  = 2'd1,
        OP_SH  = 2'd2,
        OP_ILL = 2'd3
    } store_op_t;

    // One buffered store: word address, byte enables, lane-replicated data.
    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buf_if.sv
// Request (MEM stage) and drain (data memory) handshakes of the store buffer.
// Latency: n/a (wiring only).
// Backpressure: req_ready from the buffer; mem_ready from memory.
interface store_buf_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    // Pipeline + memory side: issues stores, accepts drained entries.
    modport master (
        output req_valid, req_op, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata
    );

    // Buffer side.
    modport slave (
        input  req_valid, req_op, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/store_align.sv
// Store aligner: op + low address bits + right-justified data -> byte enables, replicated data, misaligned flag.
// Latency: purely combinational.
// Backpressure: none; caller decides what to do with a misaligned store.
module store_align
    import store_buf_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Decode per op; op 3 is always illegal regardless of address.
    always_comb begin
        be         = 4'b0000;
        wdata      = data;
        misaligned = 1'b0;
        case (op)
            OP_SW: begin
                be         = 4'b1111;
                wdata      = data;
                misaligned = (addr_lo != 2'b00);
            end
            OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            OP_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buf.sv
// Store buffer: aligns stores, coalesces same-word stores into the tail, drains in order to data memory.
// Latency: an accepted store appears on mem_* the cycle after acceptance; no same-cycle pass-through.
// Backpressure: req_ready = registered count < DEPTH (ignores same-cycle pop); head holds while mem_ready is low.
module store_buf
    import store_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    store_buf_if.slave  bus,
    output logic        misalign,
    output logic [31:0] err_addr,
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    sb_entry_t        entries [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    tail_ptr;
    logic [AW:0]      count;

    logic [3:0]       al_be;
    logic [31:0]      al_data;
    logic             al_bad;

    logic             accept;
    logic             pop;
    logic             push;
    logic             coalesce;
    sb_entry_t        head;
    sb_entry_t        tail_merged;
    logic [DEPTH-1:0] slot_vld;
    logic             unused_chk;

    store_align u_align (
        .op         (bus.req_op),
        .addr_lo    (bus.req_addr[1:0]),
        .data       (bus.req_data),
        .be         (al_be),
        .wdata      (al_data),
        .misaligned (al_bad)
    );

    assign bus.req_ready = (count < CNT_FULL);
    assign bus.mem_valid = (count != '0);
    assign empty         = (count == '0);

    assign accept   = bus.req_valid && bus.req_ready;
    assign pop      = bus.mem_valid && bus.mem_ready;
    assign tail_ptr = wr_ptr - AW'(1);

    // With count >= 2 the tail is never the head, so merging cannot disturb a presented entry.
    assign coalesce = accept && !al_bad && (count >= CNT_TWO)
                      && (entries[tail_ptr].addr == bus.req_addr[31:2]);
    assign push     = accept && !al_bad && !coalesce;

    // Head outputs are forced to zero when empty so reset/idle values are clean.
    assign head          = entries[rd_ptr];
    assign bus.mem_addr  = bus.mem_valid ? {head.addr, 2'b00} : 32'h0;
    assign bus.mem_be    = bus.mem_valid ? head.be : 4'h0;
    assign bus.mem_wdata = bus.mem_valid ? head.data : 32'h0;

    // Tail entry with the new store's enabled lanes overlaid.
    always_comb begin
        tail_merged    = entries[tail_ptr];
        tail_merged.be = tail_merged.be | al_be;
        for (int i = 0; i < 4; i++) begin
            if (al_be[i]) begin
                tail_merged.data[8*i +: 8] = al_data[8*i +: 8];
            end
        end
    end

    // Entry storage: new store at the tail, or merge into the existing tail.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: bus.req_addr[31:2], be: al_be, data: al_data};
        end else if (coalesce) begin
            entries[tail_ptr] <= tail_merged;
        end
    end

    // Pointers and occupancy; a coalesce never moves the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Misaligned/illegal stores are swallowed; flag them for one cycle and keep the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
            err_addr <= 32'h0;
        end else begin
            misalign <= accept && al_bad;
            if (accept && al_bad) begin
                err_addr <= bus.req_addr;
            end
        end
    end

    // Slot i is live when its distance from the head is below the occupancy.
    always_comb begin
        slot_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = ({1'b0, AW'(i) - rd_ptr} < count);
        end
    end

    // Load-hazard check against every live entry, head included.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (entries[i].addr == chk_addr[31:2])) begin
                chk_hit = 1'b1;
            end
        end
    end

    assign unused_chk = &{1'b0, chk_addr[1:0]};

endmodule

// File: tb/tb_store_buf.sv
// Testbench for store_buf: directed scenarios with literal expectations plus randomized traffic vs a queue model.
// Latency: n/a.
// Backpressure: mem_ready driven directly and randomly.
module tb_store_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        misalign;
    logic [31:0] err_addr;
    logic [31:0] chk_addr = 32'h0;
    logic        chk_hit;
    logic        empty;

    int tests  = 0;
    int failed = 0;

    store_buf_if bus();

    store_buf #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .misalign (misalign),
        .err_addr (err_addr),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [29:0] word;
        logic [3:0]  be;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_mis = 1'b0;
    logic [31:0] m_err = 32'h0;

    bit          m_acc, m_pop, a_bad;
    logic [3:0]  a_be;
    logic [31:0] a_w;
    int          m_n;
    ent_t        m_tmp;

    // A store of `size` bytes covers lanes off..off+size-1; every lane carries data byte (lane % size).
    function automatic void align_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                                      output bit bad, output logic [3:0] be, output logic [31:0] w);
        int size;
        int off;
        size = (op == 2'd0) ? 4 : (op == 2'd1) ? 1 : 2;
        off  = int'(a % 4);
        bad  = (op == 2'd3) || ((off % size) != 0);
        be   = 4'h0;
        w    = 32'h0;
        for (int j = 0; j < 4; j++) begin
            w[8*j +: 8] = d[8*(j % size) +: 8];
            if (j >= off && j < off + size) be[j] = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_mis = 1'b0;
            m_err = 32'h0;
        end else begin
            m_n   = mq.size();
            m_acc = bus.req_valid && (m_n < DEPTH);
            m_pop = (m_n != 0) && bus.mem_ready;
            m_mis = 1'b0;
            if (m_acc) begin
                align_ref(bus.req_op, bus.req_addr, bus.req_data, a_bad, a_be, a_w);
                if (a_bad) begin
                    m_mis = 1'b1;
                    m_err = bus.req_addr;
                end else if (m_n >= 2 && mq[m_n-1].word == bus.req_addr[31:2]) begin
                    m_tmp = mq[m_n-1];
                    for (int j = 0; j < 4; j++) begin
                        if (a_be[j]) m_tmp.data[8*j +: 8] = a_w[8*j +: 8];
                    end
                    m_tmp.be  = m_tmp.be | a_be;
                    mq[m_n-1] = m_tmp;
                end else begin
                    m_tmp.word = bus.req_addr[31:2];
                    m_tmp.be   = a_be;
                    m_tmp.data = a_w;
                    mq.push_back(m_tmp);
                end
            end
            if (m_pop) void'(mq.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    logic        e_hit;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    always @(negedge clk) begin
        e_hit = 1'b0;
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].word == chk_addr[31:2]) e_hit = 1'b1;
        end
        e_addr  = (mq.size() != 0) ? {mq[0].word, 2'b00} : 32'h0;
        e_be    = (mq.size() != 0) ? mq[0].be : 4'h0;
        e_wdata = (mq.size() != 0) ? mq[0].data : 32'h0;
        chk("m_mem_valid", 32'(bus.mem_valid), 32'(mq.size() != 0));
        chk("m_req_ready", 32'(bus.req_ready), 32'(mq.size() < DEPTH));
        chk("m_empty",     32'(empty),         32'(mq.size() == 0));
        chk("m_mem_addr",  bus.mem_addr,       e_addr);
        chk("m_mem_be",    32'(bus.mem_be),    32'(e_be));
        chk("m_mem_wdata", bus.mem_wdata,      e_wdata);
        chk("m_misalign",  32'(misalign),      32'(m_mis));
        chk("m_err_addr",  err_addr,           m_err);
        chk("m_chk_hit",   32'(chk_hit),       32'(e_hit));
    end

    // ---------------- stimulus ----------------
    // Inputs set here are sampled by the next rising edge; outputs read afterwards reflect the previous edge.
    task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input bit mr);
        @(negedge clk);
        #1;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic idle(input bit mr);
        drive(1'b0, 2'd0, 32'h0, 32'h0, mr);
    endtask

    int r;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = 32'h0;
        bus.req_data  = 32'h0;
        bus.mem_ready = 1'b0;

        // Reset values
        #3;
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_empty",     32'(empty),         32'h1);
        chk("rst_misalign",  32'(misalign),      32'h0);
        chk("rst_err_addr",  err_addr,           32'h0);
        chk("rst_mem_be",    32'(bus.mem_be),    32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'h0);
        chk("rst_mem_addr",  bus.mem_addr,       32'h0);
        chk("rst_chk_hit",   32'(chk_hit),       32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single sb: no pass-through, then visible next cycle
        drive(1'b1, 2'd1, 32'h1003, 32'h000000AB, 1'b0);
        chk("sb_no_passthru", 32'(bus.mem_valid), 32'h0);
        idle(1'b0);
        chk("sb_valid", 32'(bus.mem_valid), 32'h1);
        chk("sb_addr",  bus.mem_addr,       32'h00001000);
        chk("sb_be",    32'(bus.mem_be),    32'h8);
        chk("sb_wdata", bus.mem_wdata,      32'hABABABAB);
        idle(1'b1);
        idle(1'b0);
        chk("sb_drained", 32'(empty), 32'h1);

        // Coalesce: sb then sh to the same word merge into the second entry
        drive(1'b1, 2'd0, 32'h10, 32'h11111111, 1'b0);
        drive(1'b1, 2'd1, 32'h20, 32'h000000AA, 1'b0);
        drive(1'b1, 2'd2, 32'h22, 32'h0000BEEF, 1'b0);
        idle(1'b0);
        chk("co_head_addr", bus.mem_addr, 32'h10);
        chk("co_head_data", bus.mem_wdata, 32'h11111111);
        idle(1'b1);
        idle(1'b0);
        chk("co_second_addr", bus.mem_addr, 32'h20);
        chk("co_second_be",   32'(bus.mem_be), 32'hD);
        chk("co_second_hi",   32'(bus.mem_wdata[31:16]), 32'hBEEF);
        chk("co_second_lo",   32'(bus.mem_wdata[7:0]),   32'hAA);
        idle(1'b1);
        idle(1'b0);
        chk("co_count_two", 32'(empty), 32'h1);

        // Full and backpressure
        for (int k = 0; k < 4; k++) drive(1'b1, 2'd0, 32'h100 + 32'(4*k), 32'hC0DE0000 + 32'(k), 1'b0);
        drive(1'b1, 2'd0, 32'h200, 32'h55, 1'b0);
        chk("full_ready", 32'(bus.req_ready), 32'h0);
        idle(1'b0);
        chk("full_ready_held", 32'(bus.req_ready), 32'h0);
        chk("full_head_stable", bus.mem_addr, 32'h100);
        idle(1'b1);
        chk("drain_0", bus.mem_addr, 32'h100);
        for (int k = 1; k < 4; k++) begin
            idle(1'b1);
            chk("drain_k", bus.mem_addr, 32'h100 + 32'(4*k));
        end
        idle(1'b0);
        chk("drain_empty", 32'(empty), 32'h1);

        // Misaligned / illegal stores
        drive(1'b1, 2'd2, 32'h41, 32'h1234, 1'b0);
        idle(1'b0);
        chk("mis_sh_pulse", 32'(misalign), 32'h1);
        chk("mis_sh_addr",  err_addr,      32'h41);
        idle(1'b0);
        chk("mis_sh_drop",  32'(misalign), 32'h0);
        chk("mis_sh_hold",  err_addr,      32'h41);
        drive(1'b1, 2'd0, 32'h46, 32'h5678, 1'b0);
        idle(1'b0);
        chk("mis_sw_pulse", 32'(misalign), 32'h1);
        chk("mis_sw_addr",  err_addr,      32'h46);
        drive(1'b1, 2'd3, 32'h80, 32'h9ABC, 1'b0);
        idle(1'b0);
        chk("mis_ill_pulse", 32'(misalign), 32'h1);
        chk("mis_ill_addr",  err_addr,      32'h80);
        chk("mis_empty",     32'(empty),    32'h1);

        // chk_hit
        drive(1'b1, 2'd1, 32'h205, 32'h5A, 1'b0);
        idle(1'b0);
        chk_addr = 32'h204; #1;
        chk("hit_same_word", 32'(chk_hit), 32'h1);
        chk_addr = 32'h208; #1;
        chk("hit_other_word", 32'(chk_addr == 32'h208 && chk_hit == 1'b0), 32'h1);
        chk_addr = 32'h304;
        drive(1'b1, 2'd1, 32'h305, 32'h66, 1'b0);
        chk("hit_not_inflight", 32'(chk_hit), 32'h0);
        idle(1'b1);
        chk("hit_after_accept", 32'(chk_hit), 32'h1);
        chk_addr = 32'h204;
        idle(1'b1);
        idle(1'b0);
        chk("hit_after_drain", 32'(chk_hit), 32'h0);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) drive(1'b1, 2'd0, 32'h400 + 32'(4*k), 32'hF00 + 32'(k), 1'b0);
        idle(1'b0);
        chk("rm_pending", 32'(bus.mem_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_valid_drop", 32'(bus.mem_valid), 32'h0);
        chk("rm_ready",      32'(bus.req_ready), 32'h1);
        chk("rm_empty",      32'(empty),         32'h1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 2'd1, 32'h503, 32'h7E, 1'b0);
        idle(1'b0);
        chk("rm_new_addr",  bus.mem_addr,    32'h500);
        chk("rm_new_be",    32'(bus.mem_be), 32'h8);
        chk("rm_new_wdata", bus.mem_wdata,   32'h7E7E7E7E);
        idle(1'b1);
        idle(1'b0);
        chk("rm_new_drained", 32'(empty), 32'h1);

        // Randomized traffic over a few words to exercise coalescing, fill and hazards
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 99) < 60,
                  (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                  32'h300 + 32'($urandom_range(0, 15)),
                  $urandom,
                  $urandom_range(0, 99) < 55);
            chk_addr = 32'h300 + 32'($urandom_range(0, 19));
        end
        for (int c = 0; c < 8; c++) idle(1'b1);
        idle(1'b0);
        chk("final_empty", 32'(empty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
